piu_pchlist_builder: RTL and testbench

Builds a patch-list bitmap from a stream of patch indices. It is the inverse of the PIU patch indexer: the indexer turns a bitmap into indices, lowest set bit first, and this block turns indices back into a bitmap. Indices are accepted one per cycle over a valid/ready handshake and ORed into an accumulator. The list is committed on a last-flag and held for a downstream consumer (pch_list_reg / esmon_reg / merged_reg loaders) until that consumer accepts it.

---
 rtl/piu_pchlist_builder_pkg.sv | 13 +
 rtl/piu_pchlist_builder_pchidx_decoder.sv | 23 ++
 rtl/piu_pchlist_builder.sv | 113 +++++++++++
 tb/tb_piu_pchlist_builder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/piu_pchlist_builder_pkg.sv
// Shared patch sizing and patch-list builder state encodings.
package piu_pchlist_builder_pkg;

    localparam int NUM_PCH    = 20;
    localparam int PCHADDR_BW = 5;

    typedef enum logic [1:0] {
        PCHLB_IDLE    = 2'd0,
        PCHLB_COLLECT = 2'd1,
        PCHLB_HOLD    = 2'd2
    } pchlb_state_e;

endpackage

// File: rtl/piu_pchlist_builder_pchidx_decoder.sv
// Patch index to one-hot patch mask; inverse of the patch indexer.
module piu_pchidx_decoder
    import piu_pchlist_builder_pkg::*;
#(
    parameter int P_NUM_PCH    = NUM_PCH,
    parameter int P_PCHADDR_BW = PCHADDR_BW
) (
    input  logic [P_PCHADDR_BW-1:0] i_idx,
    output logic [P_NUM_PCH-1:0]    o_onehot,
    output logic                    o_in_range
);

    localparam logic [P_PCHADDR_BW:0] LP_LIMIT = (P_PCHADDR_BW+1)'(P_NUM_PCH);

    always_comb begin
        o_onehot   = '0;
        o_in_range = ({1'b0, i_idx} < LP_LIMIT);
        for (int i = 0; i < P_NUM_PCH; i++) begin
            o_onehot[i] = (i_idx == P_PCHADDR_BW'(i));
        end
    end

endmodule

// File: rtl/piu_pchlist_builder.sv
// Accumulates a stream of patch indices into a committed patch-list bitmap.
module piu_pchlist_builder
    import piu_pchlist_builder_pkg::*;
#(
    parameter int P_NUM_PCH    = NUM_PCH,
    parameter int P_PCHADDR_BW = PCHADDR_BW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [P_PCHADDR_BW-1:0] in_pchidx,
    input  logic                    in_last,
    input  logic                    in_flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [P_NUM_PCH-1:0]    out_pch_list,
    output logic [P_PCHADDR_BW:0]   out_count,
    output logic                    out_err_dup,
    output logic                    out_err_range
);

    localparam logic [P_PCHADDR_BW:0] LP_CNT_ONE = 1;

    pchlb_state_e r_state;
    pchlb_state_e w_state_nxt;

    logic [P_NUM_PCH-1:0]  r_acc;
    logic [P_PCHADDR_BW:0] r_cnt;
    logic                  r_dup;
    logic                  r_rng;

    logic [P_NUM_PCH-1:0]  w_onehot;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_hold;
    logic                  w_release;
    logic                  w_bit_set;

    piu_pchidx_decoder #(
        .P_NUM_PCH    (P_NUM_PCH),
        .P_PCHADDR_BW (P_PCHADDR_BW)
    ) u_dec (
        .i_idx      (in_pchidx),
        .o_onehot   (w_onehot),
        .o_in_range (w_in_range)
    );

    assign w_hold    = (r_state == PCHLB_HOLD);
    assign in_ready  = !w_hold;
    assign w_accept  = in_valid && in_ready;
    assign w_release = w_hold && out_ready;
    assign w_bit_set = |(r_acc & w_onehot);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            PCHLB_IDLE, PCHLB_COLLECT: begin
                // A flush alongside an accept still takes the index.
                if ((w_accept && in_last) || in_flush) begin
                    w_state_nxt = PCHLB_HOLD;
                end else if (w_accept) begin
                    w_state_nxt = PCHLB_COLLECT;
                end
            end
            PCHLB_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = PCHLB_IDLE;
                end
            end
            default: w_state_nxt = PCHLB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PCHLB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_dup <= 1'b0;
            r_rng <= 1'b0;
        end else if (w_release) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_dup <= 1'b0;
            r_rng <= 1'b0;
        end else if (w_accept) begin
            if (!w_in_range) begin
                r_rng <= 1'b1;
            end else if (w_bit_set) begin
                r_dup <= 1'b1;
            end else begin
                r_acc <= r_acc | w_onehot;
                r_cnt <= r_cnt + LP_CNT_ONE;
            end
        end
    end

    // The accumulator is frozen in HOLD, so it doubles as the held list.
    assign out_valid     = w_hold;
    assign out_pch_list  = w_hold ? r_acc : '0;
    assign out_count     = w_hold ? r_cnt : '0;
    assign out_err_dup   = w_hold && r_dup;
    assign out_err_range = w_hold && r_rng;

endmodule

// File: tb/tb_piu_pchlist_builder.sv
// Directed self-checking bench for the patch-list builder.
module tb_piu_pchlist_builder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_pchidx;
    logic        in_last;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_pch_list;
    logic [5:0]  out_count;
    logic        out_err_dup;
    logic        out_err_range;

    int errors;
    int checks;

    piu_pchlist_builder dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pchidx     (in_pchidx),
        .in_last       (in_last),
        .in_flush      (in_flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pch_list  (out_pch_list),
        .out_count     (out_count),
        .out_err_dup   (out_err_dup),
        .out_err_range (out_err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] idx, input logic last);
        in_valid  = 1'b1;
        in_pchidx = idx;
        in_last   = last;
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [19:0] list,
                           input logic [5:0] cnt, input logic dup,
                           input logic rng);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_list"}, 32'(out_pch_list), 32'(list));
        chk({tag, "_count"}, 32'(out_count), 32'(cnt));
        chk({tag, "_dup"}, 32'(out_err_dup), 32'(dup));
        chk({tag, "_range"}, 32'(out_err_range), 32'(rng));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, "_iready"}, 32'(in_ready), 32'd1);
        chk({tag, "_list0"}, 32'(out_pch_list), 32'd0);
        chk({tag, "_cnt0"}, 32'(out_count), 32'd0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pchidx = '0;
        in_last   = 1'b0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk_idle("reset");
        chk("reset_dup", 32'(out_err_dup), 32'd0);
        chk("reset_rng", 32'(out_err_range), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic list 3,0,7
        send(5'd3, 1'b0);
        chk("basic_mid_valid", 32'(out_valid), 32'd0);
        send(5'd0, 1'b0);
        send(5'd7, 1'b1);
        chk_out("basic", 20'h00089, 6'd3, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle("basic_after");

        // duplicate
        send(5'd5, 1'b0);
        send(5'd5, 1'b0);
        send(5'd2, 1'b1);
        chk_out("dup", 20'h00024, 6'd2, 1'b1, 1'b0);
        @(negedge clk);
        chk_idle("dup_after");

        // out of range
        send(5'd25, 1'b0);
        send(5'd19, 1'b1);
        chk_out("range", 20'h80000, 6'd1, 1'b0, 1'b1);
        @(negedge clk);
        chk_idle("range_after");

        // backpressure and round trip
        out_ready = 1'b0;
        send(5'd1, 1'b0);
        send(5'd4, 1'b1);
        in_valid  = 1'b1;
        in_pchidx = 5'd9;
        in_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_out("bp", 20'h00012, 6'd2, 1'b0, 1'b0);
            chk("bp_iready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_idle("bp_release");
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_out("bp_nine", 20'h00200, 6'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle("bp_after");

        // flush from idle
        in_flush = 1'b1;
        @(negedge clk);
        in_flush = 1'b0;
        chk_out("flush_empty", 20'h0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle("flush_empty_after");

        // flush concurrent with index
        send(5'd2, 1'b0);
        in_flush  = 1'b1;
        in_valid  = 1'b1;
        in_pchidx = 5'd6;
        in_last   = 1'b0;
        @(negedge clk);
        in_flush = 1'b0;
        in_valid = 1'b0;
        chk_out("flush_cc", 20'h00044, 6'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle("flush_cc_after");

        // async reset in COLLECT
        send(5'd8, 1'b0);
        #2 rst = 1'b1;
        #1 chk_idle("arst_collect");
        #1 rst = 1'b0;
        @(negedge clk);
        send(5'd8, 1'b1);
        chk_out("arst_collect_next", 20'h00100, 6'd1, 1'b0, 1'b0);
        @(negedge clk);

        // async reset in HOLD
        out_ready = 1'b0;
        send(5'd10, 1'b1);
        chk("arst_hold_pre", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1 chk_idle("arst_hold");
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send(5'd11, 1'b1);
        chk_out("arst_hold_next", 20'h00800, 6'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
